box_destroy_ctrl: RTL



---
 rtl/box_pkg.sv | 37 +++
 rtl/box_anim_slot.sv | 55 +++++
 rtl/box_destroy_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/box_pkg.sv
// Shared types and helpers for the breakable-box controller: box life-cycle
// encoding, scan FSM encoding and the explosion/box overlap test.
package box_pkg;

    localparam int BOX_W   = 16;
    localparam int FRAME_W = 2;

    typedef enum logic [1:0] {
        BOX_ALIVE = 2'd0,
        BOX_DYING = 2'd1,
        BOX_DEAD  = 2'd2
    } box_state_e;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_BUSY = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_e;

    // Evaluated in 11 bits so a box near the right/bottom edge cannot wrap.
    function automatic logic boxes_overlap(
        input logic [9:0]  ax,
        input logic [9:0]  ay,
        input logic [9:0]  bx,
        input logic [9:0]  by,
        input logic [10:0] w
    );
        logic [10:0] ax_e, ay_e, bx_e, by_e;
        ax_e = {1'b0, ax};
        ay_e = {1'b0, ay};
        bx_e = {1'b0, bx};
        by_e = {1'b0, by};
        return (ax_e < bx_e + w) && (ax_e + w > bx_e) &&
               (ay_e < by_e + w) && (ay_e + w > by_e);
    endfunction

endpackage

// File: rtl/box_anim_slot.sv
// One box slot: tracks ALIVE -> DYING -> DEAD and the destruction animation
// frame. A hit on the same edge as an animation step takes priority.
module box_anim_slot
    import box_pkg::*;
#(
    parameter int   ANIM_FRAMES = 4,
    parameter logic INIT_ALIVE  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_i,
    input  logic               anim_step_i,
    output box_state_e         state_o,
    output logic [FRAME_W-1:0] frame_o
);

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(ANIM_FRAMES - 1);

    box_state_e         state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        if (hit_i && state_q == BOX_ALIVE) begin
            state_d = BOX_DYING;
            frame_d = '0;
        end else if (anim_step_i && state_q == BOX_DYING) begin
            if (frame_q == LAST_FRAME) begin
                state_d = BOX_DEAD;
                frame_d = '0;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT_ALIVE ? BOX_ALIVE : BOX_DEAD;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    assign state_o = state_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/box_destroy_ctrl.sv
// Box life-cycle controller: accepts explosion cells over valid/ready, scans
// one box per cycle for overlap, and drives the alive/dying/solid masks.
module box_destroy_ctrl
    import box_pkg::*;
#(
    parameter int                   NUM_BOXES   = 8,
    parameter int                   BOX_W       = box_pkg::BOX_W,
    parameter int                   ANIM_FRAMES = 4,
    parameter int                   FRAME_TICKS = 6,
    parameter logic [NUM_BOXES-1:0] INIT_ALIVE  = {NUM_BOXES{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic [10*NUM_BOXES-1:0]      box_x_flat,
    input  logic [10*NUM_BOXES-1:0]      box_y_flat,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [9:0]                   exp_x,
    input  logic [9:0]                   exp_y,
    output logic                         scan_done,
    output logic [3:0]                   hit_count,
    output logic [NUM_BOXES-1:0]         box_alive,
    output logic [NUM_BOXES-1:0]         box_dying,
    output logic [NUM_BOXES-1:0]         box_solid,
    output logic [FRAME_W*NUM_BOXES-1:0] box_frame
);

    localparam int IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam int DIV_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BOXES - 1);
    localparam logic [DIV_W-1:0] LAST_TICK = DIV_W'(FRAME_TICKS - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       exp_x_q, exp_x_d, exp_y_q, exp_y_d;
    logic [3:0]       acc_q, acc_d, hit_count_q, hit_count_d;
    logic             scan_done_q, scan_done_d;
    logic             exp_ready_q, exp_ready_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             anim_step;
    logic             cur_hit;
    logic [9:0]       cur_x, cur_y;

    box_state_e         slot_state [NUM_BOXES];
    logic [FRAME_W-1:0] slot_frame [NUM_BOXES];

    // Only one comparator: the box under test is muxed in by the scan index.
    assign cur_x   = box_x_flat[10*idx_q +: 10];
    assign cur_y   = box_y_flat[10*idx_q +: 10];
    assign cur_hit = (state_q == SCAN_BUSY) && (slot_state[idx_q] == BOX_ALIVE) &&
                     boxes_overlap(exp_x_q, exp_y_q, cur_x, cur_y, 11'(BOX_W));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exp_x_d     = exp_x_q;
        exp_y_d     = exp_y_q;
        acc_d       = acc_q;
        hit_count_d = hit_count_q;
        scan_done_d = 1'b0;
        unique case (state_q)
            SCAN_IDLE: begin
                if (exp_valid && exp_ready_q) begin
                    exp_x_d = exp_x;
                    exp_y_d = exp_y;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN_BUSY;
                end
            end
            SCAN_BUSY: begin
                acc_d = acc_q + {3'b000, cur_hit};
                if (idx_q == LAST_IDX) begin
                    hit_count_d = acc_q + {3'b000, cur_hit};
                    scan_done_d = 1'b1;
                    state_d     = SCAN_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SCAN_DONE: state_d = SCAN_IDLE;
            default:   state_d = SCAN_IDLE;
        endcase
        exp_ready_d = (state_d == SCAN_IDLE);
    end

    // Free-running divider: the box's first frame may be shortened.
    always_comb begin
        div_d     = div_q;
        anim_step = 1'b0;
        if (frame_tick) begin
            if (div_q == LAST_TICK) begin
                div_d     = '0;
                anim_step = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN_IDLE;
            idx_q       <= '0;
            exp_x_q     <= '0;
            exp_y_q     <= '0;
            acc_q       <= '0;
            hit_count_q <= '0;
            scan_done_q <= 1'b0;
            exp_ready_q <= 1'b1;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exp_x_q     <= exp_x_d;
            exp_y_q     <= exp_y_d;
            acc_q       <= acc_d;
            hit_count_q <= hit_count_d;
            scan_done_q <= scan_done_d;
            exp_ready_q <= exp_ready_d;
            div_q       <= div_d;
        end
    end

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_slot
        box_anim_slot #(
            .ANIM_FRAMES (ANIM_FRAMES),
            .INIT_ALIVE  (INIT_ALIVE[i])
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .hit_i       (cur_hit && (idx_q == IDX_W'(i))),
            .anim_step_i (anim_step),
            .state_o     (slot_state[i]),
            .frame_o     (slot_frame[i])
        );

        assign box_alive[i] = (slot_state[i] == BOX_ALIVE);
        assign box_dying[i] = (slot_state[i] == BOX_DYING);
        assign box_solid[i] = box_alive[i] | box_dying[i];
        assign box_frame[FRAME_W*i +: FRAME_W] = slot_frame[i];
    end

    assign exp_ready = exp_ready_q;
    assign scan_done = scan_done_q;
    assign hit_count = hit_count_q;

endmodule
